// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared definitions for fifo_drain_ctrl: FSM state encoding and default timing constants.
package fifo_drain_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    localparam int unsigned DEF_GAP_CYC = 16;
    localparam int unsigned DEF_ACK_TMO = 255;
    localparam int unsigned GAP_CNT_W   = 16;

endpackage

// File: rtl/fifo_drain_ctrl_cyc_timer.sv
// cyc_timer: loadable down-counter that saturates at zero; done is high while the count is zero.
module cyc_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);
    logic [W-1:0] cnt;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pops the UART TX FIFO one word at a time into the serializer.
// Defining FIFO_DRAIN_STAT_EN adds a frame counter (tx_count) with synchronous clear (cnt_clr).
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC,
    parameter int unsigned ACK_TMO = DEF_ACK_TMO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cts,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_next,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    output logic             busy,
    output logic             err,
`ifdef FIFO_DRAIN_STAT_EN
    input  logic             cnt_clr,
    output logic [15:0]      tx_count,
`endif
    input  logic             err_clr
);
    localparam int unsigned          TMO_W       = $clog2(ACK_TMO + 1);
    localparam logic [TMO_W-1:0]     TMO_LOAD    = TMO_W'(ACK_TMO - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD    = (GAP_CYC == 0) ? '0 : GAP_CNT_W'(GAP_CYC - 1);
    localparam state_t               AFTER_FRAME = (GAP_CYC == 0) ? S_IDLE : S_GAP;

    state_t state, state_nx;
    logic   tmo_load, tmo_dec, tmo_done;
    logic   gap_load, gap_dec, gap_done;
    logic   timeout;

    // Timers are loaded one count short so done marks the last cycle of the window.
    cyc_timer #(.W(TMO_W)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load),
        .load_val (TMO_LOAD),
        .dec      (tmo_dec),
        .done     (tmo_done)
    );

    cyc_timer #(.W(GAP_CNT_W)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .done     (gap_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nx  = state;
        fifo_next = 1'b0;
        tx_start  = 1'b0;
        tmo_load  = 1'b0;
        tmo_dec   = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && cts && !fifo_empty) state_nx = S_LOAD;
            end
            S_LOAD: begin
                fifo_next = 1'b1;
                state_nx  = S_START;
            end
            S_START: begin
                tx_start = 1'b1;
                tmo_load = 1'b1;
                state_nx = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                tmo_dec = 1'b1;
                if (tx_busy) begin
                    state_nx = S_WAIT_DONE;
                end else if (tmo_done) begin
                    timeout  = 1'b1;
                    gap_load = 1'b1;
                    state_nx = AFTER_FRAME;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_load = 1'b1;
                    state_nx = AFTER_FRAME;
                end
            end
            S_GAP: begin
                gap_dec = 1'b1;
                if (gap_done) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  tx_data <= '0;
        else if (state == S_LOAD) tx_data <= fifo_data;
    end

    // A timeout on the same edge as err_clr leaves err set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err <= 1'b0;
        else if (timeout) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

`ifdef FIFO_DRAIN_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           tx_count <= 16'd0;
        else if (cnt_clr)  tx_count <= 16'd0;
        else if (tx_start) tx_count <= tx_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: FIFO and serializer stand-ins, a procedural reference model
// compared every cycle, directed scenarios with hand-computed expectations, then random traffic.
module tb_fifo_drain_ctrl;
    localparam int W     = 8;
    localparam int G     = 16;
    localparam int T     = 5;
    localparam int NEVER = 1_000_000;

    logic         clk = 1'b0, rst = 1'b0, en = 1'b0, cts = 1'b0;
    logic         fifo_empty = 1'b1, tx_busy = 1'b0, err_clr = 1'b0;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_next, tx_start, busy, err;
    logic [W-1:0] tx_data;
`ifdef FIFO_DRAIN_STAT_EN
    logic         cnt_clr = 1'b0;
    logic [15:0]  tx_count;
`endif

    fifo_drain_ctrl #(.WIDTH(W), .GAP_CYC(G), .ACK_TMO(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cts        (cts),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_next  (fifo_next),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .err        (err),
`ifdef FIFO_DRAIN_STAT_EN
        .cnt_clr    (cnt_clr),
        .tx_count   (tx_count),
`endif
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one frame per loop pass, sampled at rising edges
    logic         m_next = 1'b0, m_start = 1'b0, m_busy = 1'b0, m_err = 1'b0;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] exp_q[$];

    task automatic m_tick(output bit ab);
        @(posedge clk or posedge rst);
        ab = rst;
        if (!ab && err_clr) m_err = 1'b0;
    endtask

    task automatic m_run();
        bit ab;
        bit acked;
        forever begin
            m_busy = 1'b0;
            do begin
                m_tick(ab);
                if (ab) return;
            end while (!(en && cts && !fifo_empty));
            m_busy = 1'b1;
            m_next = 1'b1;
            m_tick(ab);
            if (ab) return;
            m_next  = 1'b0;
            m_start = 1'b1;
            if (exp_q.size() > 0) m_data = exp_q.pop_front();
            m_tick(ab);
            if (ab) return;
            m_start = 1'b0;
            acked   = 1'b0;
            for (int k = 1; k <= T; k++) begin
                m_tick(ab);
                if (ab) return;
                if (tx_busy) begin
                    acked = 1'b1;
                    break;
                end
            end
            if (acked) begin
                do begin
                    m_tick(ab);
                    if (ab) return;
                end while (tx_busy);
            end else begin
                m_err = 1'b1;
            end
            for (int k = 0; k < G; k++) begin
                m_tick(ab);
                if (ab) return;
            end
        end
    endtask

    initial begin
        wait (rst == 1'b1);
        forever begin
            m_next = 1'b0; m_start = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_data = '0;
            wait (rst == 1'b0);
            m_run();
        end
    end

    initial begin
        wait (rst == 1'b1);
        forever begin
            @(negedge clk);
            check("fifo_next", fifo_next, m_next);
            check("tx_start",  tx_start,  m_start);
            check("busy",      busy,      m_busy);
            check("err",       err,       m_err);
            check("tx_data",   tx_data,   m_data);
        end
    end

    // ---------------- FIFO and serializer stand-ins, advanced only at falling edges
    logic [W-1:0] fifo_q[$];
    int cyc = 0;
    int ser_on = NEVER, ser_off = NEVER;
    int ser_d = 1, ser_b = 10;
    bit pop_pend = 1'b0;

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        refresh();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pend = fifo_next;
        if (tx_start) begin
            ser_on  = (ser_d >= NEVER) ? NEVER : cyc + ser_d;
            ser_off = ser_on + ser_b;
        end
        tx_busy = (cyc >= ser_on) && (cyc < ser_off);
        refresh();
    endtask

    task automatic reset_mid();
        #2;
        rst      = 1'b1;
        pop_pend = 1'b0;
        ser_on   = NEVER;
        ser_off  = NEVER;
        tx_busy  = 1'b0;
    endtask

    task automatic wait_pop(input int lim, output int n);
        n = 0;
        while (fifo_next !== 1'b1 && n < lim) begin
            step();
            n++;
        end
        check("pop_seen", fifo_next, 1);
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while (busy !== 1'b0 && n < lim) begin
            step();
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        int pops[$];
        logic [W-1:0] words[$];

        #1 rst = 1'b1;
        repeat (3) step();
        check("rst_fifo_next", fifo_next, 0);
        check("rst_tx_start",  tx_start,  0);
        check("rst_busy",      busy,      0);
        check("rst_err",       err,       0);
        check("rst_tx_data",   tx_data,   0);
        rst = 1'b0;

        // single word: pop one cycle after the request, start the cycle after that
        en = 1'b1; cts = 1'b1; ser_d = 1; ser_b = 10;
        push(8'hA5);
        wait_pop(10, n);
        check("t1_pop_latency", n, 1);
        step();
        check("t1_start", tx_start, 1);
        check("t1_next_low", fifo_next, 0);
        check("t1_data", tx_data, 8'hA5);
        wait_idle(100, n);
        check("t1_start_to_idle", n, 2 + 10 + G);

        // burst of three: in order, spaced 4 + busy + gap
        push(8'h01); push(8'h02); push(8'h03);
        for (int i = 0; i < 150; i++) begin
            step();
            if (fifo_next) pops.push_back(cyc);
            if (tx_start) words.push_back(tx_data);
        end
        check("t2_pop_count", pops.size(), 3);
        check("t2_word_count", words.size(), 3);
        if (pops.size() == 3) begin
            check("t2_spacing_1", pops[1] - pops[0], 4 + 10 + G);
            check("t2_spacing_2", pops[2] - pops[1], 4 + 10 + G);
        end
        if (words.size() == 3) begin
            check("t2_word_0", words[0], 8'h01);
            check("t2_word_1", words[1], 8'h02);
            check("t2_word_2", words[2], 8'h03);
        end
        check("t2_idle", busy, 0);

        // flow control
        cts = 1'b0;
        push(8'h3C);
        pulses = 0;
        repeat (20) begin step(); pulses += int'(fifo_next); end
        check("t3_blocked_pops", pulses, 0);
        cts = 1'b1;
        wait_pop(5, n);
        check("t3_pop_on_cts", n, 1);
        step();
        cts = 1'b0;
        push(8'h3D);
        wait_idle(100, n);
        pulses = 0;
        repeat (40) begin step(); pulses += int'(fifo_next); end
        check("t3_blocked_after_frame", pulses, 0);
        cts = 1'b1;
        wait_pop(5, n);
        check("t3_resume", n, 1);
        wait_idle(100, n);

        // ack timeout: err five cycles into WAIT_ACK, busy held through the gap
        ser_d = NEVER;
        push(8'h77);
        wait_pop(5, n);
        n = 0;
        while (err !== 1'b1 && n < 20) begin step(); n++; end
        check("t4_err_latency", n, 7);
        check("t4_busy_at_err", busy, 1);
        wait_idle(40, n);
        check("t4_gap_len", n, G);
        check("t4_err_sticky", err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4_err_cleared", err, 0);
        err_clr = 1'b1;
        push(8'h78);
        wait_pop(5, n);
        repeat (7) step();
        check("t4_timeout_beats_clr", err, 1);
        step();
        check("t4_clr_after", err, 0);
        err_clr = 1'b0;
        wait_idle(40, n);

        // reset in WAIT_DONE: outputs drop at once, remaining words drain
        ser_d = 1; ser_b = 10;
        push(8'h11); push(8'h22); push(8'h33);
        wait_pop(5, n);
        repeat (5) step();
        check("t5_busy_before", busy, 1);
        reset_mid();
        #1;
        check("t5_async_fifo_next", fifo_next, 0);
        check("t5_async_tx_start",  tx_start,  0);
        check("t5_async_busy",      busy,      0);
        check("t5_async_err",       err,       0);
        check("t5_async_tx_data",   tx_data,   0);
        step(); step();
        rst = 1'b0;
        words.delete();
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx_start) words.push_back(tx_data);
        end
        check("t5_word_count", words.size(), 2);
        if (words.size() == 2) begin
            check("t5_word_0", words[0], 8'h22);
            check("t5_word_1", words[1], 8'h33);
        end

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 9) == 0) push(W'($urandom_range(0, 255)));
            en      = ($urandom_range(0, 9) != 0);
            cts     = ($urandom_range(0, 7) != 0);
            err_clr = ($urandom_range(0, 19) == 0);
            ser_d   = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, T + 2));
            ser_b   = int'($urandom_range(1, 8));
            if ($urandom_range(0, 499) == 0) begin
                reset_mid();
                step();
                rst = 1'b0;
            end
            step();
        end
        en = 1'b1; cts = 1'b1; err_clr = 1'b0; ser_d = 1;
        n = 0;
        while ((fifo_q.size() > 0 || busy) && n < 2000) begin step(); n++; end
        check("drain_fifo_empty", fifo_empty, 1);
        check("drain_idle", busy, 0);

`ifdef FIFO_DRAIN_STAT_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("t6_count_cleared", tx_count, 0);
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        n = 0;
        while ((fifo_q.size() > 0 || busy) && n < 500) begin step(); n++; end
        check("t6_count_four", tx_count, 4);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
